vga_pattern_gen: RTL and testbench

Parametrised successor to the lab's fixed 640x480 smiley generator. It produces VGA timing (hsync, vsync, blank) and one of four selectable test patterns, with the timing and colour width set by parameters. Frame-synchronous mode switching and an animated mode are added. The block sits between the board-level clock divider and the DE-series VGA DAC pins, and is driven by a pixel-rate enable instead of an internal PLL.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing.sv | 72 +++++++
 rtl/vga_pattern_gen.sv | 215 +++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
// Mode and direction enums, bar palette, default 640x480 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } vga_mode_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  // {R,G,B} on/off per bar, index 0 is the leftmost bar
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010,
    3'b101, 3'b100, 3'b001, 3'b000
  };

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with sync, active and frame strobes.
// Everything here is decoded from the current counter value.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_pix_en,
  output logic [HW-1:0] o_hc,
  output logic [VW-1:0] o_vc,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active,
  output logic          o_eof,
  output logic          o_first
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int VS_BEG  = V_ACTIVE + V_FP;

  logic [HW-1:0] r_hc;
  logic [VW-1:0] r_vc;
  logic          w_h_last;
  logic          w_v_last;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;

  assign w_h_last = r_hc == HW'(H_TOTAL - 1);
  assign w_v_last = r_vc == VW'(V_TOTAL - 1);
  assign w_h32    = 32'(r_hc);
  assign w_v32    = 32'(r_vc);

  // advance the raster position once per pixel strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (i_pix_en) begin
      if (w_h_last) begin
        r_hc <= '0;
        r_vc <= w_v_last ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  assign o_hc     = r_hc;
  assign o_vc     = r_vc;
  assign o_hsync  = (w_h32 >= HS_BEG) &&
                    (w_h32 < HS_BEG + H_SYNC);
  assign o_vsync  = (w_v32 >= VS_BEG) &&
                    (w_v32 < VS_BEG + V_SYNC);
  assign o_active = (w_h32 < H_ACTIVE) &&
                    (w_v32 < V_ACTIVE);
  assign o_eof    = w_h_last && w_v_last;
  assign o_first  = (r_hc == '0) && (r_vc == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: mode latch, bouncing box,
// pattern select and the registered DAC outputs.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = 8,
  parameter int   CHK_LOG  = 5,
  parameter int   BOX      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_en,
  input  logic [1:0]      mode_req,
  input  logic [3*CW-1:0] fg_color,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_BLANK_N,
  output logic [CW-1:0]   VGA_R,
  output logic [CW-1:0]   VGA_G,
  output logic [CW-1:0]   VGA_B,
  output logic            frame_start,
  output logic [7:0]      frame_cnt
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [HW-1:0] BAR_W_H  = HW'(BAR_W);
  localparam logic [HW-1:0] BARS_END = HW'(8 * BAR_W);
  localparam logic [HW-1:0] X_MAX    = HW'(H_ACTIVE - BOX);
  localparam logic [VW-1:0] Y_MAX    = VW'(V_ACTIVE - BOX);
  localparam logic [HW-1:0] BOX_H    = HW'(BOX);
  localparam logic [VW-1:0] BOX_V    = VW'(BOX);

  logic [HW-1:0]   w_hc;
  logic [VW-1:0]   w_vc;
  logic            w_hsync;
  logic            w_vsync;
  logic            w_active;
  logic            w_eof;
  logic            w_first;
  logic            w_frame_end;

  vga_mode_t       r_mode;
  logic [HW-1:0]   r_box_x;
  logic [VW-1:0]   r_box_y;
  dir_t            r_dx;
  dir_t            r_dy;
  logic [HW-1:0]   w_box_x_n;
  logic [VW-1:0]   w_box_y_n;
  dir_t            w_dx_n;
  dir_t            w_dy_n;

  logic [2:0]      w_bar_idx;
  logic [2:0]      w_bar;
  logic            w_in_box;
  logic [3*CW-1:0] w_rgb;

  logic            r_hs;
  logic            r_vs;
  logic            r_blank_n;
  logic [3*CW-1:0] r_rgb;
  logic            r_fs;
  logic [7:0]      r_frame_cnt;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .i_pix_en (pix_en),
    .o_hc     (w_hc),
    .o_vc     (w_vc),
    .o_hsync  (w_hsync),
    .o_vsync  (w_vsync),
    .o_active (w_active),
    .o_eof    (w_eof),
    .o_first  (w_first)
  );

  assign w_frame_end = w_eof && pix_en;

  // frame-boundary state: mode, box position/direction, frame count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode      <= MODE_SOLID;
      r_box_x     <= '0;
      r_box_y     <= '0;
      r_dx        <= DIR_POS;
      r_dy        <= DIR_POS;
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_mode      <= vga_mode_t'(mode_req);
      r_box_x     <= w_box_x_n;
      r_box_y     <= w_box_y_n;
      r_dx        <= w_dx_n;
      r_dy        <= w_dy_n;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // bounce step: reverse at an edge, otherwise move one pixel
  always_comb begin
    w_box_x_n = r_box_x;
    w_box_y_n = r_box_y;
    w_dx_n    = r_dx;
    w_dy_n    = r_dy;
    unique case (1'b1)
      (r_dx == DIR_POS) && (r_box_x == X_MAX): begin
        w_dx_n    = DIR_NEG;
        w_box_x_n = r_box_x - 1'b1;
      end
      (r_dx == DIR_NEG) && (r_box_x == '0): begin
        w_dx_n    = DIR_POS;
        w_box_x_n = HW'(1);
      end
      (r_dx == DIR_POS) && (r_box_x != X_MAX):
        w_box_x_n = r_box_x + 1'b1;
      (r_dx == DIR_NEG) && (r_box_x != '0):
        w_box_x_n = r_box_x - 1'b1;
    endcase
    unique case (1'b1)
      (r_dy == DIR_POS) && (r_box_y == Y_MAX): begin
        w_dy_n    = DIR_NEG;
        w_box_y_n = r_box_y - 1'b1;
      end
      (r_dy == DIR_NEG) && (r_box_y == '0): begin
        w_dy_n    = DIR_POS;
        w_box_y_n = VW'(1);
      end
      (r_dy == DIR_POS) && (r_box_y != Y_MAX):
        w_box_y_n = r_box_y + 1'b1;
      (r_dy == DIR_NEG) && (r_box_y != '0):
        w_box_y_n = r_box_y - 1'b1;
    endcase
  end

  assign w_bar_idx = 3'(w_hc / BAR_W_H);
  assign w_bar     = BAR_RGB[w_bar_idx];
  assign w_in_box  = (w_hc >= r_box_x) &&
                     (w_hc < r_box_x + BOX_H) &&
                     (w_vc >= r_box_y) &&
                     (w_vc < r_box_y + BOX_V);

  // colour of the pixel at the current raster position
  always_comb begin
    w_rgb = '0;
    if (w_active) begin
      unique case (r_mode)
        MODE_SOLID:
          w_rgb = fg_color;
        MODE_BARS:
          if (w_hc < BARS_END)
            w_rgb = {{CW{w_bar[2]}},
                     {CW{w_bar[1]}},
                     {CW{w_bar[0]}}};
        MODE_CHECK:
          if (!(w_hc[CHK_LOG] ^ w_vc[CHK_LOG]))
            w_rgb = fg_color;
        MODE_BOUNCE:
          if (w_in_box)
            w_rgb = fg_color;
      endcase
    end
  end

  // output register, advanced only by the pixel strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs      <= ~SYNC_POL;
      r_vs      <= ~SYNC_POL;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (pix_en) begin
      r_hs      <= w_hsync ? SYNC_POL : ~SYNC_POL;
      r_vs      <= w_vsync ? SYNC_POL : ~SYNC_POL;
      r_blank_n <= w_active;
      r_rgb     <= w_rgb;
    end
  end

  // single-clock pulse following the enabled (0,0) cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fs <= 1'b0;
    else        r_fs <= pix_en && w_first;
  end

  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_R       = r_rgb[3*CW-1 -: CW];
  assign VGA_G       = r_rgb[2*CW-1 -: CW];
  assign VGA_B       = r_rgb[CW-1:0];
  assign frame_start = r_fs;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen with a reduced raster (28x17).
// Per-cycle model compare plus literal pixel expectations.
module tb_vga_pattern_gen;

  localparam int HA = 20, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int CL = 2;
  localparam int BX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b1;
  logic [1:0]  mode_req = 2'd0;
  logic [23:0] fg_color = 24'h123456;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int errs = 0;
  int checks = 0;
  bit tog = 1'b0;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b0), .CW(8), .CHK_LOG(CL), .BOX(BX)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .mode_req(mode_req), .fg_color(fg_color),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // bouncing coordinate after n frame ends over range 0..r
  function automatic int tri_pos(input int n, input int r);
    int p;
    p = n % (2 * r);
    return (p <= r) ? p : 2 * r - p;
  endfunction

  function automatic logic [23:0] pix(input int mode,
    input int h, input int v, input int n,
    input logic [23:0] fg);
    logic [23:0] bars [8];
    int bw, bx, by;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (h >= HA || v >= VA) return 24'h0;
    case (mode)
      0: return fg;
      1: begin
        bw = HA / 8;
        if (h >= 8 * bw) return 24'h0;
        return bars[h / bw];
      end
      2: return (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 24'h0 : fg;
      default: begin
        bx = tri_pos(n, HA - BX);
        by = tri_pos(n, VA - BX);
        if (h >= bx && h < bx + BX && v >= by && v < by + BX)
          return fg;
        return 24'h0;
      end
    endcase
  endfunction

  // model state: next raster position, frames ended, latched mode
  int m_h = 0, m_v = 0, m_n = 0, m_mode = 0;
  int o_h = -1, o_v = 0, o_n = 0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_bn = 1'b0, e_fs = 1'b0;
  logic [23:0] e_rgb = 24'h0;
  logic [7:0]  e_fc = 8'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_h <= 0; m_v <= 0; m_n <= 0; m_mode <= 0;
      o_h <= -1; o_v <= 0; o_n <= 0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_bn <= 1'b0;
      e_fs <= 1'b0; e_rgb <= 24'h0; e_fc <= 8'h0;
    end else begin
      e_fs <= pix_en && m_h == 0 && m_v == 0;
      if (pix_en) begin
        e_rgb <= pix(m_mode, m_h, m_v, m_n, fg_color);
        e_hs  <= !(m_h >= HA + HFP && m_h < HA + HFP + HSY);
        e_vs  <= !(m_v >= VA + VFP && m_v < VA + VFP + VSY);
        e_bn  <= m_h < HA && m_v < VA;
        o_h <= m_h; o_v <= m_v; o_n <= m_n;
        if (m_h == HT - 1) begin
          m_h <= 0;
          if (m_v == VT - 1) begin
            m_v <= 0;
            m_n <= m_n + 1;
            m_mode <= int'(mode_req);
            e_fc <= 8'(m_n + 1);
          end else begin
            m_v <= m_v + 1;
          end
        end else begin
          m_h <= m_h + 1;
        end
      end
    end
  end

  // captured output frames, ring of four indexed by frame number
  logic [23:0] c_rgb [4][VT][HT];
  logic        c_hs  [4][VT][HT];
  logic        c_vs  [4][VT][HT];
  logic        c_bn  [4][VT][HT];

  always @(negedge clk) begin
    checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, frame_cnt,
         VGA_R, VGA_G, VGA_B} !==
        {e_hs, e_vs, e_bn, e_fs, e_fc, e_rgb}) begin
      errs++;
      if (errs < 20)
        $display("FAIL stream h=%0d v=%0d n=%0d got hs%b vs%b bn%b fs%b fc%0d rgb%h want hs%b vs%b bn%b fs%b fc%0d rgb%h",
          o_h, o_v, o_n, VGA_HS, VGA_VS, VGA_BLANK_N,
          frame_start, frame_cnt, {VGA_R, VGA_G, VGA_B},
          e_hs, e_vs, e_bn, e_fs, e_fc, e_rgb);
    end
    if (reset && o_h >= 0) begin
      c_rgb[o_n % 4][o_v][o_h] = {VGA_R, VGA_G, VGA_B};
      c_hs[o_n % 4][o_v][o_h]  = VGA_HS;
      c_vs[o_n % 4][o_v][o_h]  = VGA_VS;
      c_bn[o_n % 4][o_v][o_h]  = VGA_BLANK_N;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic px(input string nm, input int f, input int h,
                    input int v, input logic [23:0] want);
    chk(nm, {8'h0, c_rgb[f % 4][v][h]}, {8'h0, want});
  endtask

  task automatic wait_frame(input int f, input int lim);
    int k;
    k = 0;
    while (o_n <= f && k < lim) begin
      @(negedge clk);
      if (tog) pix_en = ~pix_en;
      k++;
    end
    chk("frame_timeout", o_n > f, 1);
  endtask

  task automatic wait_pos(input int f, input int v, input int h);
    int k;
    k = 0;
    while (!(m_n == f && m_v == v && m_h == h) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("pos_timeout", k < 20000, 1);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_hs", VGA_HS, 1);
    chk("rst_vs", VGA_VS, 1);
    chk("rst_bn", VGA_BLANK_N, 0);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    reset = 1'b1;

    // frame 0 solid; request checker mid-frame
    wait_pos(0, 6, 0);
    mode_req = 2'd2;
    fg_color = 24'h0000FF;
    wait_frame(0, 2000);
    mode_req = 2'd1;
    cnt = 0;
    for (int h = 0; h < HT; h++) if (!c_hs[0][0][h]) cnt++;
    chk("hs_width", cnt, HSY);
    chk("hs_first", c_hs[0][0][HA + HFP], 0);
    chk("hs_before", c_hs[0][0][HA + HFP - 1], 1);
    cnt = 0;
    for (int v = 0; v < VT; v++) if (!c_vs[0][v][0]) cnt++;
    chk("vs_lines", cnt, VSY);
    chk("vs_first", c_vs[0][VA + VFP][0], 0);
    cnt = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) if (c_bn[0][v][h]) cnt++;
    chk("blank_cnt", cnt, HA * VA);
    px("solid_00", 0, 0, 0, 24'h123456);
    px("solid_after_req", 0, 4, 8, 24'h0000FF);
    px("porch_black", 0, HA, 0, 24'h0);

    wait_frame(1, 2000);
    mode_req = 2'd3;
    px("chk_00", 1, 0, 0, 24'h0000FF);
    px("chk_40", 1, 4, 0, 24'h0);
    px("chk_44", 1, 4, 4, 24'h0000FF);
    px("chk_04", 1, 0, 4, 24'h0);

    wait_frame(2, 2000);
    px("bar_w", 2, 0, 0, 24'hFFFFFF);
    px("bar_y", 2, 2, 0, 24'hFFFF00);
    px("bar_c", 2, 5, 3, 24'h00FFFF);
    px("bar_r", 2, 10, 0, 24'hFF0000);
    px("bar_b", 2, 13, 0, 24'h0000FF);
    px("bar_k", 2, 15, 0, 24'h0);
    px("bar_rem", 2, 16, 0, 24'h0);
    px("bar_last", 2, HA - 1, 11, 24'h0);

    wait_frame(9, 5000);
    px("box8_in", 8, 8, 8, 24'h0000FF);
    px("box8_far", 8, 11, 11, 24'h0000FF);
    px("box8_rt", 8, 12, 8, 24'h0);
    px("box8_up", 8, 8, 7, 24'h0);
    px("box9_in", 9, 9, 7, 24'h0000FF);
    px("box9_lt", 9, 8, 7, 24'h0);
    px("box9_bot", 9, 9, 11, 24'h0);

    wait_frame(17, 5000);
    px("box16_in", 16, 16, 0, 24'h0000FF);
    px("box16_far", 16, 19, 3, 24'h0000FF);
    px("box16_lt", 16, 15, 0, 24'h0);
    px("box16_dn", 16, 16, 4, 24'h0);
    px("box17_in", 17, 15, 1, 24'h0000FF);
    px("box17_far", 17, 18, 4, 24'h0000FF);
    px("box17_rt", 17, 19, 1, 24'h0);
    px("box17_up", 17, 15, 0, 24'h0);

    // asynchronous reset mid-frame
    wait_pos(18, 5, 10);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_hs", VGA_HS, 1);
    chk("mid_rst_vs", VGA_VS, 1);
    chk("mid_rst_bn", VGA_BLANK_N, 0);
    chk("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("mid_rst_fs", frame_start, 0);
    chk("mid_rst_fc", frame_cnt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // half-rate pixel strobe over two frames
    tog = 1'b1;
    wait_frame(1, 5000);
    tog = 1'b0;
    pix_en = 1'b1;
    px("half_solid", 0, 0, 0, 24'h0000FF);
    px("half_box_in", 1, 1, 1, 24'h0000FF);
    px("half_box_far", 1, 4, 4, 24'h0000FF);
    px("half_box_lt", 1, 0, 1, 24'h0);
    px("half_box_rt", 1, 5, 4, 24'h0);

    // frozen strobe, then resume
    pix_en = 1'b0;
    repeat (40) @(negedge clk);
    pix_en = 1'b1;
    repeat (100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
